// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives combinational imem, buffers two words for decode.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_a,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        out_misalign
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } count_e;

  count_e      count_q, count_d;
  logic [31:0] pc_q, pc_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        halt_q, halt_d;
  logic [31:0] buf_instr_q [2];
  logic [31:0] buf_pc_q    [2];

  logic        fetch_en;
  logic        push;
  logic        pop;
  logic        push_mis;
  logic [31:0] push_instr;
  logic [31:0] redirect_tgt;

  // Fetch never looks at out_ready, so there is no ready->PC combinational path.
  assign fetch_en = (count_q != FULL) && !halt_q && !redirect_valid;
  assign push     = fetch_en;
  assign pop      = out_valid && out_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic buf_mis_q [2];

  assign push_mis     = (pc_q[1:0] != 2'b00);
  assign redirect_tgt = redirect_pc;

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      buf_mis_q[wr_ptr_q] <= push_mis;
    end
  end

  assign out_misalign = out_valid && buf_mis_q[rd_ptr_q];
`else
  assign push_mis     = 1'b0;
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign out_misalign = 1'b0;
`endif

  assign push_instr = push_mis ? NOP_INSTR : imem_rd;

  always_comb begin
    count_d  = count_q;
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    halt_d   = halt_q;
    if (redirect_valid) begin
      count_d  = EMPTY;
      pc_d     = redirect_tgt;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      halt_d   = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = ~wr_ptr_q;
        // A trap entry parks the PC on the faulting address until redirected.
        if (push_mis) halt_d = 1'b1;
        else          pc_d   = pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = (count_q == EMPTY) ? HALF : FULL;
        2'b01:   count_d = (count_q == FULL) ? HALF : EMPTY;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= EMPTY;
      pc_q     <= RESET_PC;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      halt_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      halt_q   <= halt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      buf_instr_q[wr_ptr_q] <= push_instr;
      buf_pc_q[wr_ptr_q]    <= pc_q;
    end
  end

  assign imem_a       = pc_q;
  assign out_valid    = (count_q != EMPTY);
  assign out_instr    = out_valid ? buf_instr_q[rd_ptr_q] : NOP_INSTR;
  assign out_pc       = out_valid ? buf_pc_q[rd_ptr_q] : 32'h0;
  assign out_pc_plus4 = out_pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a queue-based reference.
// Honours FETCH_MISALIGN_TRAP_EN the same way as the design.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic [31:0] imem_a;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        out_misalign;

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_a         (imem_a),
    .imem_rd        (imem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .out_misalign   (out_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0113;
      32'h4:   return 32'h0010_0193;
      default: return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  assign imem_rd = mem_word(imem_a);

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        mis;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic        m_halt;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] e_instr, e_pc;
    logic        e_mis;
    e_instr = NOP_INSTR;
    e_pc    = 32'h0;
    e_mis   = 1'b0;
    if (mq.size() > 0) begin
      e_instr = mq[0].instr;
      e_pc    = mq[0].pc;
      e_mis   = mq[0].mis;
    end
    check("imem_a",       imem_a,              m_pc);
    check("out_valid",    {31'b0, out_valid},  {31'b0, mq.size() > 0});
    check("out_instr",    out_instr,           e_instr);
    check("out_pc",       out_pc,              e_pc);
    check("out_pc_plus4", out_pc_plus4,        e_pc + 32'd4);
    check("out_misalign", {31'b0, out_misalign}, {31'b0, e_mis});
  endtask

  // Apply inputs for one cycle, advance the reference, then check after the edge.
  task automatic step(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
    bit   full;
    ent_t e;
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    if (rst) begin
      mq.delete();
      m_pc   = RESET_PC;
      m_halt = 1'b0;
    end else begin
      full = (mq.size() == 2);
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (rv) begin
        mq.delete();
        m_halt = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        m_pc = rpc;
`else
        m_pc = {rpc[31:2], 2'b00};
`endif
      end else if (!full && !m_halt) begin
`ifdef FETCH_MISALIGN_TRAP_EN
        if (m_pc[1:0] != 2'b00) begin
          e.instr = NOP_INSTR; e.pc = m_pc; e.mis = 1'b1;
          mq.push_back(e);
          m_halt = 1'b1;
        end else begin
          e.instr = mem_word(m_pc); e.pc = m_pc; e.mis = 1'b0;
          mq.push_back(e);
          m_pc = m_pc + 32'd4;
        end
`else
        e.instr = mem_word(m_pc); e.pc = m_pc; e.mis = 1'b0;
        mq.push_back(e);
        m_pc = m_pc + 32'd4;
`endif
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    logic [31:0] tgt;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    m_pc = RESET_PC; m_halt = 1'b0;

    // Reset then streaming with out_ready high.
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    check("rst_imem_a", imem_a, 32'h0);
    check("rst_instr", out_instr, 32'h0000_0013);
    step(0, 0, 0, 1);
    check("first_valid", {31'b0, out_valid}, 32'd1);
    check("first_instr", out_instr, 32'h0050_0113);
    check("first_pc4", out_pc_plus4, 32'h4);
    step(0, 0, 0, 1);
    check("second_instr", out_instr, 32'h0010_0193);
    check("second_pc", out_pc, 32'h4);

    // Backpressure fills the buffer, then drains with no gap.
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    check("full_imem_a", imem_a, 32'h8);
    check("full_head", out_instr, 32'h0050_0113);
    step(0, 0, 0, 1);
    check("drain_pc4", out_pc, 32'h4);
    step(0, 0, 0, 1);
    check("drain_pc8", out_pc, 32'h8);

    // Redirect while full, head consumed on the same edge.
    step(0, 0, 0, 0);
    step(0, 1, 32'h40, 1);
    check("redir_empty", {31'b0, out_valid}, 32'd0);
    check("redir_imem_a", imem_a, 32'h40);
    step(0, 0, 0, 0);
    check("redir_head", out_pc, 32'h40);

    // Misaligned redirect.
    step(0, 1, 32'h42, 0);
    step(0, 0, 0, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_pc", out_pc, 32'h42);
    check("mis_flag", {31'b0, out_misalign}, 32'd1);
    check("mis_instr", out_instr, 32'h13);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    check("mis_halt_a", imem_a, 32'h42);
    step(0, 0, 0, 1);
    check("mis_halt_v", {31'b0, out_valid}, 32'd0);
`else
    check("mis_pc", out_pc, 32'h40);
    check("mis_flag", {31'b0, out_misalign}, 32'd0);
`endif
    step(0, 1, 32'h0, 1);
    step(0, 0, 0, 1);

    // PC wrap.
    step(0, 1, 32'hFFFF_FFFC, 1);
    step(0, 0, 0, 0);
    check("wrap_pc", out_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", out_pc_plus4, 32'h0);
    step(0, 0, 0, 1);
    check("wrap_next", out_pc, 32'h0);

    // Reset with two buffered entries.
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    check("midrst_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_imem_a", imem_a, RESET_PC);
    check("midrst_instr", out_instr, 32'h13);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: tgt = $urandom & 32'hFFFF_FFFC;
        1: tgt = $urandom;
        2: tgt = 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2);
        default: tgt = $urandom_range(0, 63) << 2;
      endcase
      step($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0, tgt,
           $urandom_range(0, 2) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
